// File: rtl/mux_pkg.sv
// Shared sizing constants and helpers for the 256:1 single-bit mux tree.
package mux_pkg;

  localparam int MUX_N     = 256;
  localparam int MUX_SEL_W = 8;

  // Number of binary tree levels needed to reduce n leaves to one root.
  function automatic int mux_levels(input int n);
    int l;
    l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

endpackage

// File: rtl/mux256to1_if.sv
// Bit-select bus: data vector and index in, combinational and registered pick out.
interface mux256to1_if
  import mux_pkg::*;
#(
  parameter int N     = MUX_N,
  parameter int SEL_W = MUX_SEL_W
);

  logic [N-1:0]     in;
  logic [SEL_W-1:0] sel;
  logic             out;
  logic             out_q;

  modport master (output in, sel, input out, out_q);
  modport slave  (input in, sel, output out, out_q);

endinterface

// File: rtl/mux2.sv
// 2:1 single-bit primitive; leaf cell of the select tree.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux256to1.sv
// Single-bit N:1 mux built as a balanced tree of mux2 cells, plus a registered copy.
module mux256to1
  import mux_pkg::*;
#(
  parameter int N     = MUX_N,
  parameter int SEL_W = MUX_SEL_W
) (
  input logic         clk,
  input logic         rst_n,
  mux256to1_if.slave  bus
);

  localparam int LEVELS = mux_levels(N);

  if (N != (1 << SEL_W) || LEVELS != SEL_W) begin : g_bad_size
    $fatal(1, "mux256to1: N must equal 2**SEL_W");
  end

  // Level k halves the candidate set using sel[k]; the leaves see sel[0].
  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int W = N >> (k + 1);
    logic [2*W-1:0] x;
    logic [W-1:0]   y;

    if (k == 0) begin : g_leaf
      assign x = bus.in;
    end else begin : g_inner
      assign x = g_lvl[k-1].y;
    end

    for (genvar j = 0; j < W; j++) begin : g_mux
      mux2 u_mux2 (
        .a (x[2*j]),
        .b (x[2*j+1]),
        .s (bus.sel[k]),
        .y (y[j])
      );
    end
  end

  assign bus.out = g_lvl[SEL_W-1].y[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_q <= 1'b0;
    end else begin
      bus.out_q <= g_lvl[SEL_W-1].y[0];
    end
  end

endmodule

// File: tb/tb_mux256to1.sv
// Directed and random checks of the combinational and registered bit select.
module tb_mux256to1;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mux256to1_if bus ();

  mux256to1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [255:0] v, input logic [7:0] s);
    bus.in  = v;
    bus.sel = s;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    logic [255:0] one;
    logic [255:0] msb;
    logic [255:0] v;
    logic [7:0]   s;
    logic         exp_q;

    one = 256'b1;
    msb = one << 255;

    // Reset state and combinational path while in reset
    rst_n = 1'b0;
    drive('0, 8'd0);
    #2;
    chk("reset_out_q", bus.out_q, 1'b0);
    drive(one << 3, 8'd3);
    #1;
    chk("out_in_reset", bus.out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Walking one
    for (int i = 0; i < 256; i++) begin
      drive(one << i, 8'(i));
      #1;
      chk("walk1_hit", bus.out, 1'b1);
      bus.sel = 8'(i + 1);
      #1;
      chk("walk1_miss", bus.out, 1'b0);
    end

    // Walking zero
    for (int i = 0; i < 256; i++) begin
      drive(~(one << i), 8'(i));
      #1;
      chk("walk0_hit", bus.out, 1'b0);
      bus.sel = 8'(i + 7);
      #1;
      chk("walk0_miss", bus.out, 1'b1);
    end

    // Boundaries
    drive(msb, 8'd255);
    #1;
    chk("msb_sel255", bus.out, 1'b1);
    bus.sel = 8'd0;
    #1;
    chk("msb_sel0", bus.out, 1'b0);
    drive(one, 8'd0);
    #1;
    chk("lsb_sel0", bus.out, 1'b1);
    bus.sel = 8'd255;
    #1;
    chk("lsb_sel255", bus.out, 1'b0);

    // Random, inputs changed on both clock edges
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      v = rand256();
      s = 8'($urandom_range(0, 255));
      drive(v, s);
      #1;
      chk("rand_pos", bus.out, v[s]);
      @(negedge clk);
      v = rand256();
      s = 8'($urandom_range(0, 255));
      drive(v, s);
      #1;
      chk("rand_neg", bus.out, v[s]);
    end

    // Isolation: only in[90] matters when sel = 0x5A
    for (int i = 0; i < 64; i++) begin
      v = rand256();
      v[90] = 1'b1;
      drive(v, 8'h5A);
      #1;
      chk("isolate_toggle", bus.out, 1'b1);
    end
    v = {256{1'bx}};
    v[90] = 1'b1;
    drive(v, 8'h5A);
    #1;
    chk("isolate_x", bus.out, 1'b1);

    // Registered output: one cycle latency, sampled before the edge
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: begin v = one;          s = 8'd0;   exp_q = 1'b1; end
        1: begin v = msb;          s = 8'd255; exp_q = 1'b1; end
        2: begin v = msb;          s = 8'd0;   exp_q = 1'b0; end
        3: begin v = one << 90;    s = 8'h5A;  exp_q = 1'b1; end
        default: begin v = ~(one << 90); s = 8'h5A; exp_q = 1'b0; end
      endcase
      drive(v, s);
      @(posedge clk);
      #1;
      chk("out_q_latency", bus.out_q, exp_q);
    end

    // Reset asserted mid-run
    @(negedge clk);
    drive(one << 7, 8'd7);
    @(posedge clk);
    #1;
    chk("pre_reset_q", bus.out_q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", bus.out_q, 1'b0);
    drive('0, 8'd7);
    #1;
    chk("reset_out_track0", bus.out, 1'b0);
    drive(one << 7, 8'd7);
    #1;
    chk("reset_out_track1", bus.out, 1'b1);
    @(posedge clk);
    #1;
    chk("reset_hold", bus.out_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_edge", bus.out_q, 1'b0);
    @(posedge clk);
    #1;
    chk("release_first", bus.out_q, 1'b1);
    @(negedge clk);
    drive(one << 7, 8'd8);
    @(posedge clk);
    #1;
    chk("release_second", bus.out_q, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
